// File: rtl/arbiter_client.sv
// arbiter_client
//   Client-side requester for a round-robin arbiter. A burst of burst_len
//   granted beats is requested on start. Once granted, each cycle with gnt
//   high is one beat. Losing gnt mid-burst puts the client back into
//   REQUEST, and the remaining beats are kept. Waiting too long for a grant
//   abandons the burst. Every finished or abandoned burst is followed by a
//   holdoff period with req low.
//
// Parameters
//   TIMEOUT_CYCLES : cycles spent in REQUEST without a grant before giving up
//   HOLDOFF_CYCLES : cycles with req low after a burst/timeout (0 acts as 1)
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start      in   request a burst (sampled only in IDLE)
//   burst_len  in   [3:0] beats wanted, sampled with start
//   gnt        in   grant from the arbiter
//   req        out  request to the arbiter (REQUEST or TRANSFER)
//   xfer_valid out  this cycle is a transfer beat
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse when a burst completes
//   timeout    out  one-cycle pulse when a request is abandoned
//   beats_left out  [3:0] beats still owed in the current burst
module arbiter_client #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] burst_len,
    input  logic       gnt,
    output logic       req,
    output logic       xfer_valid,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [3:0] beats_left
);

    localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int HOLD_W = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLDOFF_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        TRANSFER,
        HOLD
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic [HOLD_W-1:0] hold_cnt;

    // Saturating increment: the counter sticks at its maximum instead of wrapping.
    assign wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);

    // Decoded straight from the state register, so reset clears them immediately.
    assign req        = (state == REQUEST) || (state == TRANSFER);
    assign busy       = (state != IDLE);
    assign xfer_valid = (state == TRANSFER) && gnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            beats_left <= 4'd0;
            wait_cnt   <= '0;
            hold_cnt   <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (burst_len != 4'd0) begin
                            beats_left <= burst_len;
                            wait_cnt   <= '0;
                            state      <= REQUEST;
                        end else begin
                            // Empty burst completes at once without touching the arbiter.
                            done <= 1'b1;
                        end
                    end
                end
                REQUEST: begin
                    // The grant edge only accepts; beats start in TRANSFER.
                    if (gnt) begin
                        state <= TRANSFER;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_inc >= WAIT_LIMIT) begin
                            timeout  <= 1'b1;
                            hold_cnt <= HOLD_LOAD;
                            state    <= HOLD;
                        end
                    end
                end
                TRANSFER: begin
                    if (gnt) begin
                        beats_left <= beats_left - 4'd1;
                        if (beats_left == 4'd1) begin
                            done     <= 1'b1;
                            hold_cnt <= HOLD_LOAD;
                            state    <= HOLD;
                        end
                    end else begin
                        // Preempted: re-request the remaining beats with a fresh wait budget.
                        wait_cnt <= '0;
                        state    <= REQUEST;
                    end
                end
                HOLD: begin
                    // A load of 0 or 1 both give a single holdoff cycle.
                    if (hold_cnt <= HOLD_W'(1)) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/arbiter_client.md
ARBITER_CLIENT -- requirements
Module: arbiter_client

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum number of cycles spent in REQUEST before abandoning the request.
REQ-002 Parameter HOLDOFF_CYCLES, default 2: number of cycles req stays low after a burst or timeout before a new start is accepted.
REQ-003 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: request a burst; sampled only in IDLE.
REQ-006 Port burst_len, input, 4: number of granted beats wanted; sampled with start.
REQ-007 Port gnt, input, 1: grant from the round-robin arbiter, active high.
REQ-008 Port req, output, 1: request to the arbiter, active high.
REQ-009 Port xfer_valid, output, 1: the current cycle is a transfer beat.
REQ-010 Port busy, output, 1: high in every state except IDLE.
REQ-011 Port done, output, 1: one-cycle pulse when a burst completes.
REQ-012 Port timeout, output, 1: one-cycle pulse when a request is abandoned.
REQ-013 Port beats_left, output, 4: beats still owed in the current burst.

Function
REQ-014 The FSM shall have exactly four states: IDLE, REQUEST, TRANSFER, HOLD; state, beat counter, wait counter, holdoff counter, done and timeout shall be registers.
REQ-015 req shall be high exactly when state is REQUEST or TRANSFER.
REQ-016 xfer_valid shall equal (state==TRANSFER) AND gnt.
REQ-017 In IDLE, start=1 with burst_len!=0 shall load beats_left=burst_len, clear the wait counter and enter REQUEST; req rises in the next cycle.
REQ-018 In IDLE, start=1 with burst_len==0 shall pulse done in the next cycle and remain in IDLE, with req never asserted.
REQ-019 start shall be ignored in REQUEST, TRANSFER and HOLD.
REQ-020 In REQUEST, gnt=1 at a clock edge shall move to TRANSFER; this acceptance cycle is not a beat.
REQ-021 In REQUEST, gnt=0 shall increment the wait counter each cycle.
REQ-022 When the wait counter reaches TIMEOUT_CYCLES, the block shall pulse timeout for one cycle, enter HOLD and leave beats_left unchanged.
REQ-023 In TRANSFER, each edge with gnt=1 shall decrement beats_left by 1.
REQ-024 The edge that takes beats_left from 1 to 0 shall enter HOLD and pulse done in the following cycle, with req low in that same cycle.
REQ-025 In TRANSFER, gnt=0 (preemption) shall return to REQUEST with beats_left preserved and the wait counter cleared; no beat is counted on that edge.
REQ-026 HOLD shall last exactly HOLDOFF_CYCLES cycles with req=0, then enter IDLE; HOLDOFF_CYCLES=0 shall go to IDLE after one cycle.
REQ-027 The wait counter shall be wide enough for TIMEOUT_CYCLES and shall saturate, never wrap.
REQ-028 done and timeout shall never both be high in the same cycle.

Reset
REQ-029 reset=1 shall immediately, without waiting for a clock edge, force state=IDLE, req=0, xfer_valid=0, busy=0, done=0, timeout=0, beats_left=0, and clear all counters.
REQ-030 Reset asserted mid-burst shall abandon the burst with no done or timeout pulse; after release, the first accepted start shall behave as in REQ-017.

Verification
REQ-031 Start with burst_len=3; gnt high 2 cycles after req rises and held high -> 1 acceptance cycle, then xfer_valid high for 3 cycles, beats_left 3->2->1->0, done pulses once, req low for 2 cycles, then busy=0.
REQ-032 Start with burst_len=4; gnt held low -> req high for 15 cycles, timeout pulses once, beats_left stays 4, done never pulses, IDLE after 2 holdoff cycles.
REQ-033 Start with burst_len=4; gnt dropped after 2 beats for 3 cycles, then re-granted -> return to REQUEST with beats_left=2, re-acceptance cycle, then 2 more beats and done; total xfer_valid cycles = 4.
REQ-034 Start with burst_len=0 -> done pulses next cycle, req stays 0, busy stays 0.
REQ-035 Reset pulsed asynchronously between clock edges during TRANSFER with beats_left=2 -> req and xfer_valid drop before the next edge, no done pulse; a subsequent start with burst_len=1 completes normally.
REQ-036 start held high continuously with burst_len=2 and gnt always 1 -> back-to-back bursts separated by exactly 2 req-low holdoff cycles, with start ignored outside IDLE.
